// File: rtl/csa_dot_accumulator.sv
// Dot-product accumulator: sums 2*WIDTH-bit products over a programmed term count, then holds the result for a valid/ready handshake.
// Optional build macro CSA_ACC_SATURATION_EN makes the accumulator clamp to all ones on carry-out instead of wrapping.
module csa_dot_accumulator #(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 12,
    parameter int MAX_LEN   = 16,
    parameter int LEN_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [LEN_WIDTH-1:0]   length,
    input  logic [2*WIDTH-1:0]     product_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [ACC_WIDTH-1:0]   acc_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   overflow
);

    localparam int PAD = ACC_WIDTH + 1 - 2*WIDTH;
    localparam logic [LEN_WIDTH-1:0] MAX_LEN_L = LEN_WIDTH'(MAX_LEN);

    if (ACC_WIDTH < 2*WIDTH) begin : g_bad_acc_width
        $error("csa_dot_accumulator: ACC_WIDTH must be >= 2*WIDTH");
    end
    if (MAX_LEN >= (1 << LEN_WIDTH)) begin : g_bad_len_width
        $error("csa_dot_accumulator: LEN_WIDTH cannot hold MAX_LEN");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [LEN_WIDTH-1:0]   remaining_q;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic                   ovf_q;

    logic [LEN_WIDTH-1:0]   len_eff_d;
    logic [ACC_WIDTH:0]     sum_d;
    logic [ACC_WIDTH-1:0]   acc_d;

    always_comb begin
        len_eff_d = length;
        if (length > MAX_LEN_L) begin
            len_eff_d = MAX_LEN_L;
        end
        sum_d = {1'b0, acc_q} + {{PAD{1'b0}}, product_in};
`ifdef CSA_ACC_SATURATION_EN
        // Once saturated, the sum is pinned for the rest of the transaction.
        if (sum_d[ACC_WIDTH] || ovf_q) begin
            acc_d = '1;
        end else begin
            acc_d = sum_d[ACC_WIDTH-1:0];
        end
`else
        acc_d = sum_d[ACC_WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_q <= '0;
                        ovf_q <= 1'b0;
                        if (len_eff_d == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            remaining_q <= len_eff_d;
                            state_q     <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        acc_q       <= acc_d;
                        ovf_q       <= ovf_q | sum_d[ACC_WIDTH];
                        remaining_q <= remaining_q - LEN_WIDTH'(1);
                        if (remaining_q == LEN_WIDTH'(1)) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // A start seen here is dropped; it must be reasserted from IDLE.
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_csa_dot_accumulator.sv
// Bench for csa_dot_accumulator: a 12-bit and a 10-bit accumulator driven in lockstep, checked against a sum-of-products model.
module tb_csa_dot_accumulator;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [4:0]   length;
    logic [7:0]   product_in;
    logic         in_valid;
    logic         out_ready;
    logic         in_ready12, out_valid12, busy12, ovf12;
    logic         in_ready10, out_valid10, busy10, ovf10;
    logic [11:0]  acc12;
    logic [9:0]   acc10;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    csa_dot_accumulator #(.WIDTH(4), .ACC_WIDTH(12), .MAX_LEN(16), .LEN_WIDTH(5)) dut12 (
        .clk(clk), .rst_n(rst_n), .start(start), .length(length),
        .product_in(product_in), .in_valid(in_valid), .in_ready(in_ready12),
        .acc_out(acc12), .out_valid(out_valid12), .out_ready(out_ready),
        .busy(busy12), .overflow(ovf12));

    csa_dot_accumulator #(.WIDTH(4), .ACC_WIDTH(10), .MAX_LEN(16), .LEN_WIDTH(5)) dut10 (
        .clk(clk), .rst_n(rst_n), .start(start), .length(length),
        .product_in(product_in), .in_valid(in_valid), .in_ready(in_ready10),
        .acc_out(acc10), .out_valid(out_valid10), .out_ready(out_ready),
        .busy(busy10), .overflow(ovf10));

    typedef struct {
        int           len;
        logic [127:0] prods;
        int           gap;
        int           hold;
        int           e12;
        int           o12;
        int           e10;
        int           o10;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the result is just the sum of the first n products, reduced to w bits.
    function automatic void model(input int n, input logic [127:0] p, input int w,
                                  output longint res, output int ov);
        longint total = 0;
        longint lim   = longint'(1) << w;
        for (int k = 0; k < n; k++) total += longint'(p[k*8 +: 8]);
        ov = (total >= lim) ? 1 : 0;
`ifdef CSA_ACC_SATURATION_EN
        res = (ov != 0) ? lim - 1 : total;
`else
        res = total % lim;
`endif
    endfunction

    task automatic run_txn(input string tag, input int len, input logic [127:0] prods,
                           input int gap, input int hold,
                           input int e12, input int o12, input int e10, input int o10);
        int     n;
        longint p12, p10;
        int     po12, po10;
        n = (len > 16) ? 16 : len;
        start  = 1'b1;
        length = 5'(len);
        tick();
        start = 1'b0;
        if (n == 0) begin
            chk({tag, " len0 out_valid"}, out_valid12, 1);
            chk({tag, " len0 acc"}, acc12, 0);
        end else begin
            chk({tag, " in_ready"}, in_ready12, 1);
            chk({tag, " busy"}, busy10, 1);
        end
        for (int k = 0; k < n; k++) begin
            if (k > 0 && gap > 0) begin
                in_valid   = 1'b0;
                product_in = 8'($urandom_range(0, 255));
                model(k, prods, 12, p12, po12);
                model(k, prods, 10, p10, po10);
                repeat (gap) begin
                    tick();
                    chk({tag, " gap acc12"}, acc12, p12);
                    chk({tag, " gap acc10"}, acc10, p10);
                end
            end
            in_valid   = 1'b1;
            product_in = prods[k*8 +: 8];
            tick();
            in_valid = 1'b0;
            if (k < n - 1) chk({tag, " early out_valid"}, out_valid12, 0);
        end
        chk({tag, " out_valid"}, out_valid12, 1);
        chk({tag, " in_ready done"}, in_ready10, 0);
        chk({tag, " acc12"}, acc12, e12);
        chk({tag, " ovf12"}, ovf12, o12);
        chk({tag, " acc10"}, acc10, e10);
        chk({tag, " ovf10"}, ovf10, o10);
        repeat (hold) begin
            tick();
            chk({tag, " hold valid"}, out_valid10, 1);
            chk({tag, " hold acc12"}, acc12, e12);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " idle valid"}, out_valid12, 0);
        chk({tag, " idle busy"}, busy12, 0);
    endtask

    initial begin
        logic [127:0] sq;
        logic [127:0] rp;
        longint r12, r10;
        int     ov12, ov10;

        for (int k = 0; k < 16; k++) sq[k*8 +: 8] = 8'(k * k);

        vecs[0] = '{3,  {104'd0, 8'd0, 8'd30, 8'd225},                       0, 0, 255,  0, 255, 0};
        vecs[1] = '{4,  {96'd0, 8'd40, 8'd30, 8'd20, 8'd10},                 2, 5, 100,  0, 100, 0};
        vecs[2] = '{16, {16{8'd225}},                                       0, 1, 3600, 0, 528, 1};
        vecs[3] = '{16, sq,                                                 0, 0, 1240, 0, 216, 1};
        vecs[4] = '{20, sq,                                                 1, 0, 1240, 0, 216, 1};
        vecs[5] = '{0,  128'd0,                                             0, 2, 0,    0, 0,   0};
        vecs[6] = '{1,  {120'd0, 8'd255},                                   0, 0, 255,  0, 255, 0};
`ifdef CSA_ACC_SATURATION_EN
        vecs[2].e10 = 1023;
        vecs[3].e10 = 1023;
        vecs[4].e10 = 1023;
`endif

        rst_n = 1'b0; start = 1'b0; length = '0; product_in = '0;
        in_valid = 1'b0; out_ready = 1'b0;
        #3;
        chk("reset acc", acc12, 0);
        chk("reset out_valid", out_valid12, 0);
        chk("reset in_ready", in_ready12, 0);
        chk("reset busy", busy12, 0);
        chk("reset overflow", ovf12, 0);
        #10 rst_n = 1'b1;
        tick();

        // Products presented while idle must be ignored.
        in_valid = 1'b1; product_in = 8'd99;
        tick(); tick();
        in_valid = 1'b0;
        chk("idle ignore acc", acc12, 0);
        chk("idle ignore ready", in_ready12, 0);

        for (int i = 0; i < 7; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].len, vecs[i].prods, vecs[i].gap,
                    vecs[i].hold, vecs[i].e12, vecs[i].o12, vecs[i].e10, vecs[i].o10);
        end

        // Reset mid-accumulation after two terms.
        start = 1'b1; length = 5'd5; tick(); start = 1'b0;
        in_valid = 1'b1; product_in = 8'd50; tick();
        product_in = 8'd60; tick();
        in_valid = 1'b0;
        chk("pre-reset acc", acc12, 110);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset acc", acc12, 0);
        chk("midreset in_ready", in_ready12, 0);
        chk("midreset busy", busy10, 0);
        chk("midreset out_valid", out_valid12, 0);
        #2 rst_n = 1'b1;
        tick();
        chk("postreset busy", busy12, 0);

        // A start pulse during accumulation must not change the term count.
        start = 1'b1; length = 5'd2; tick();
        length = 5'd7; tick();
        start = 1'b0;
        in_valid = 1'b1; product_in = 8'd3; tick();
        product_in = 8'd4; tick();
        in_valid = 1'b0;
        chk("restart ignored valid", out_valid12, 1);
        chk("restart ignored acc", acc12, 7);

        // start together with out_ready in DONE does not launch a new transaction.
        start = 1'b1; length = 5'd3; out_ready = 1'b1; tick();
        start = 1'b0; out_ready = 1'b0;
        chk("no chain busy", busy12, 0);
        tick();
        chk("no chain still idle", busy12, 0);

        for (int t = 0; t < 25; t++) begin
            int len;
            len = $urandom_range(0, 20);
            for (int k = 0; k < 16; k++) rp[k*8 +: 8] = 8'($urandom_range(0, 255));
            model((len > 16) ? 16 : len, rp, 12, r12, ov12);
            model((len > 16) ? 16 : len, rp, 10, r10, ov10);
            run_txn($sformatf("rnd%0d", t), len, rp, $urandom_range(0, 2),
                    $urandom_range(0, 3), int'(r12), ov12, int'(r10), ov10);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
